// File: rtl/pll_lock_ctrl.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a stable lock with
// timeout and bounded retries, and releases a reset for the PLL clock domain.
module pll_lock_ctrl #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_reset,
  output logic       rst_out_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  localparam logic [16:0] RST_LAST     = 17'(RST_CYCLES - 1);
  localparam logic [16:0] STABLE_LAST  = 17'(STABLE_CYCLES - 1);
  localparam logic [16:0] TIMEOUT_LAST = 17'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRY);

  state_t      state, state_n;
  logic [16:0] cnt, cnt_n;
  logic [3:0]  retry_n;
  logic        lock_m, lock_s;

  always_comb begin
    state_n = state;
    retry_n = retry_cnt;
    if (relock_req) begin
      state_n = ST_RST;
      retry_n = '0;
    end else begin
      unique case (state)
        ST_RST: begin
          if (cnt == RST_LAST) state_n = ST_WAIT;
        end
        ST_WAIT: begin
          if (lock_s) begin
            state_n = ST_STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            if (retry_cnt == RETRY_MAX) begin
              state_n = ST_FAIL;
            end else begin
              state_n = ST_RST;
              retry_n = retry_cnt + 4'd1;
            end
          end
        end
        ST_STABLE: begin
          // loss of lock wins over the final stable cycle
          if (!lock_s)                 state_n = ST_WAIT;
          else if (cnt == STABLE_LAST) state_n = ST_RUN;
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_n = ST_RST;
            retry_n = '0;
          end
        end
        ST_FAIL: ;
        default: begin
          state_n = ST_RST;
          retry_n = '0;
        end
      endcase
    end

    // relock_req while already in RST still restarts the full reset pulse
    if (relock_req || (state_n != state)) cnt_n = '0;
    else if (cnt == '1)                   cnt_n = cnt;
    else                                  cnt_n = cnt + 17'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_m    <= 1'b0;
      lock_s    <= 1'b0;
      state     <= ST_RST;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_reset <= 1'b1;
      rst_out_n <= 1'b0;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      lock_m    <= pll_lock;
      lock_s    <= lock_m;
      state     <= state_n;
      cnt       <= cnt_n;
      retry_cnt <= retry_n;
      pll_reset <= (state_n == ST_RST);
      rst_out_n <= (state_n == ST_RUN);
      ready     <= (state_n == ST_RUN);
      fail      <= (state_n == ST_FAIL);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with small timing parameters
// (RST=4, STABLE=8, TIMEOUT=32, MAX_RETRY=2).
module tb_pll_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, pll_lock, relock_req;
  logic       pll_reset, rst_out_n, ready, fail;
  logic [3:0] retry_cnt;
  logic [2:0] state_o;

  int checks   = 0;
  int failures = 0;

  pll_lock_ctrl #(
    .RST_CYCLES(4),
    .STABLE_CYCLES(8),
    .TIMEOUT_CYCLES(32),
    .MAX_RETRY(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pll_lock(pll_lock),
    .relock_req(relock_req),
    .pll_reset(pll_reset),
    .rst_out_n(rst_out_n),
    .ready(ready),
    .fail(fail),
    .retry_cnt(retry_cnt),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  wire [10:0] obs = {pll_reset, rst_out_n, ready, fail, state_o, retry_cnt};

  // Moore output pattern expected for a given state and retry count
  function automatic logic [10:0] expv(input logic [2:0] s, input logic [3:0] r);
    return {s == 3'd0, s == 3'd3, s == 3'd3, s == 3'd4, s, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_lock = 1'b0; relock_req = 1'b0;
    step(); step();
    if (obs !== expv(3'd0, 4'd0)) begin
      failures++;
      $display("FAIL reset_state: got %b expected %b", obs, expv(3'd0, 4'd0));
    end
    checks++;
  endtask

  task automatic test_bringup();
    logic [10:0] e;
    rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      e = expv((i < 4) ? 3'd0 : 3'd1, 4'd0);
      if (obs !== e) begin
        failures++;
        $display("FAIL bringup_rst step %0d: got %b expected %b", i, obs, e);
      end
      checks++;
    end
    pll_lock = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      step();
      e = expv((i < 3) ? 3'd1 : (i < 11) ? 3'd2 : 3'd3, 4'd0);
      if (obs !== e) begin
        failures++;
        $display("FAIL bringup_lock edge %0d: got %b expected %b", i, obs, e);
      end
      checks++;
    end
  endtask

  task automatic test_loss_in_run();
    logic [10:0] e;
    pll_lock = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      e = expv((i < 3) ? 3'd3 : (i < 7) ? 3'd0 : 3'd1, 4'd0);
      if (obs !== e) begin
        failures++;
        $display("FAIL loss_in_run edge %0d: got %b expected %b", i, obs, e);
      end
      checks++;
    end
    pll_lock = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      step();
      e = expv((i < 3) ? 3'd1 : (i < 11) ? 3'd2 : 3'd3, 4'd0);
      if (obs !== e) begin
        failures++;
        $display("FAIL relock_after_loss edge %0d: got %b expected %b", i, obs, e);
      end
      checks++;
    end
  endtask

  task automatic test_glitch();
    logic [10:0] e;
    relock_req = 1'b1;
    step();
    relock_req = 1'b0;
    if (obs !== expv(3'd0, 4'd0)) begin
      failures++;
      $display("FAIL relock_in_run: got %b expected %b", obs, expv(3'd0, 4'd0));
    end
    checks++;
    for (int i = 1; i <= 10; i++) begin
      step();
      e = expv((i < 4) ? 3'd0 : (i == 4) ? 3'd1 : 3'd2, 4'd0);
      if (obs !== e) begin
        failures++;
        $display("FAIL glitch_approach step %0d: got %b expected %b", i, obs, e);
      end
      checks++;
    end
    pll_lock = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      e = expv((i < 3) ? 3'd2 : 3'd1, 4'd0);
      if (obs !== e) begin
        failures++;
        $display("FAIL glitch_drop edge %0d: got %b expected %b", i, obs, e);
      end
      checks++;
    end
    pll_lock = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      step();
      e = expv((i < 3) ? 3'd1 : (i < 11) ? 3'd2 : 3'd3, 4'd0);
      if (obs !== e) begin
        failures++;
        $display("FAIL glitch_recover edge %0d: got %b expected %b", i, obs, e);
      end
      checks++;
    end
  endtask

  task automatic test_async_reset();
    logic [10:0] e;
    #2 rst_n = 1'b0;
    pll_lock = 1'b0;
    #1;
    if (obs !== expv(3'd0, 4'd0)) begin
      failures++;
      $display("FAIL async_reset_run: got %b expected %b", obs, expv(3'd0, 4'd0));
    end
    checks++;
    step();
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) step();
    if (obs !== expv(3'd1, 4'd0)) begin
      failures++;
      $display("FAIL mid_wait_state: got %b expected %b", obs, expv(3'd1, 4'd0));
    end
    checks++;
    #3 rst_n = 1'b0;
    #1;
    if (obs !== expv(3'd0, 4'd0)) begin
      failures++;
      $display("FAIL async_reset_wait: got %b expected %b", obs, expv(3'd0, 4'd0));
    end
    checks++;
    step();
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      e = expv((i < 4) ? 3'd0 : 3'd1, 4'd0);
      if (obs !== e) begin
        failures++;
        $display("FAIL post_reset_pulse step %0d: got %b expected %b", i, obs, e);
      end
      checks++;
    end
  endtask

  task automatic test_timeout(input bit relock_last);
    logic [10:0] e;
    pll_lock = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int a = 0; a <= 2; a++) begin
      for (int i = 1; i <= 4; i++) begin
        step();
        e = expv((i < 4) ? 3'd0 : 3'd1, 4'(a));
        if (obs !== e) begin
          failures++;
          $display("FAIL timeout_rst attempt %0d step %0d: got %b expected %b", a, i, obs, e);
        end
        checks++;
      end
      for (int i = 1; i <= 31; i++) step();
      e = expv(3'd1, 4'(a));
      if (obs !== e) begin
        failures++;
        $display("FAIL timeout_wait_end attempt %0d: got %b expected %b", a, obs, e);
      end
      checks++;
      if (relock_last && a == 2) relock_req = 1'b1;
      step();
      relock_req = 1'b0;
      if (a < 2)            e = expv(3'd0, 4'(a + 1));
      else if (relock_last) e = expv(3'd0, 4'd0);
      else                  e = expv(3'd4, 4'd2);
      if (obs !== e) begin
        failures++;
        $display("FAIL timeout_exit attempt %0d: got %b expected %b", a, obs, e);
      end
      checks++;
    end
    if (!relock_last) begin
      for (int i = 1; i <= 40; i++) step();
      if (obs !== expv(3'd4, 4'd2)) begin
        failures++;
        $display("FAIL fail_hold: got %b expected %b", obs, expv(3'd4, 4'd2));
      end
      checks++;
    end
  endtask

  task automatic test_fail_relock();
    relock_req = 1'b1;
    step();
    relock_req = 1'b0;
    if (obs !== expv(3'd0, 4'd0)) begin
      failures++;
      $display("FAIL relock_in_fail: got %b expected %b", obs, expv(3'd0, 4'd0));
    end
    checks++;
    for (int i = 1; i <= 4; i++) step();
    if (obs !== expv(3'd1, 4'd0)) begin
      failures++;
      $display("FAIL relock_in_fail_wait: got %b expected %b", obs, expv(3'd1, 4'd0));
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_loss_in_run();
    test_glitch();
    test_async_reset();
    test_timeout(1'b0);
    test_fail_relock();
    test_timeout(1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_lock_ctrl.md
PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 SHALL have one clock and reset that is asynchronous, active-low.
REQ-002 Parameter: RST_CYCLES, default 16, cycles pll_reset is held high per attempt (≥2).
REQ-003 Parameter: STABLE_CYCLES, default 1024, cycles of continuous lock required before release (≥2).
REQ-004 Parameter: TIMEOUT_CYCLES, default 65536, cycles allowed in WAIT for lock (≥2, ≤2^17).
REQ-005 Parameter: MAX_RETRY, default 3, retries after the first attempt before FAIL (≤15).
REQ-006 Port: clk, in, 1, free-running PLL reference clock (same net as PLL clkin).
REQ-007 Port: rst_n, in, 1, asynchronous active-low reset.
REQ-008 Port: pll_lock, in, 1, PLL lock indication; asynchronous to clk.
REQ-009 Port: relock_req, in, 1, single-cycle synchronous request to restart the PLL.
REQ-010 Port: pll_reset, out, 1, drives the PLL reset input; active-high.
REQ-011 Port: rst_out_n, out, 1, active-low reset for logic clocked by the PLL output.
REQ-012 Port: ready, out, 1, PLL locked and stable.
REQ-013 Port: fail, out, 1, retries exhausted.
REQ-014 Port: retry_cnt, out, 4, retries used in the current bring-up.
REQ-015 Port: state_o, out, 3, current state encoding (debug).

Function
REQ-016 pll_lock SHALL pass through a 2-flop synchronizer (lock_s); all decisions use lock_s only.
REQ-017 States and encodings SHALL be: RST=0, WAIT=1, STABLE=2, RUN=3, FAIL=4; other codes go to RST.
REQ-018 A single 17-bit counter SHALL be cleared on every state change and increment each cycle otherwise.
REQ-019 RST: leave after counter==RST_CYCLES-1 and go to WAIT; this gives exactly RST_CYCLES cycles.
REQ-020 WAIT, lock_s=1: go to STABLE.
REQ-021 WAIT, counter==TIMEOUT_CYCLES-1 with lock_s=0: go to FAIL if retry_cnt==MAX_RETRY; otherwise increment retry_cnt and go to RST.
REQ-022 STABLE, lock_s=0: go to WAIT; retry_cnt unchanged; timeout window restarts.
REQ-023 STABLE, counter==STABLE_CYCLES-1 with lock_s=1: go to RUN.
REQ-024 RUN, lock_s=0: go to RST and clear retry_cnt.
REQ-025 FAIL: hold until relock_req or rst_n.
REQ-026 relock_req=1 in any state: go to RST, clear retry_cnt; this has priority over all other transitions in the same cycle.
REQ-027 Outputs SHALL be registered (Moore): pll_reset=1 only in RST; rst_out_n=1 and ready=1 only in RUN; fail=1 only in FAIL; state_o equals the state register.
REQ-028 Latency SHALL be: ready rises 3+STABLE_CYCLES clk edges after pll_lock rises in WAIT; ready/rst_out_n fall 3 edges after pll_lock falls in RUN.
REQ-029 retry_cnt SHALL never exceed MAX_RETRY and never wrap.
REQ-030 The counter SHALL not overflow: every state bounding it exits before 2^17.

Reset
REQ-031 rst_n=0 SHALL immediately force state=RST, counter=0, retry_cnt=0, synchronizer flops=0, pll_reset=1, rst_out_n=0, ready=0, fail=0.
REQ-032 Reset asserted in any state, including mid-WAIT or RUN, SHALL discard all progress; after release, the sequence restarts with a full RST_CYCLES pulse.

Verification (RST_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32, MAX_RETRY=2)
REQ-033 Normal bring-up: release rst_n, raise pll_lock 10 cycles later and hold it -> pll_reset high for the first 4 cycles; ready=rst_out_n=1 exactly 11 edges after the pll_lock rise; retry_cnt=0.
REQ-034 Lock never arrives -> three pll_reset pulses of 4 cycles, each followed by 32 WAIT cycles; then fail=1, state_o=4, retry_cnt=2, and the state holds indefinitely.
REQ-035 Lock glitch in STABLE: pll_lock low for 3 cycles at STABLE cycle 5 -> return to WAIT; ready stays 0; retry_cnt unchanged; ready rises 11 edges after pll_lock returns.
REQ-036 Loss of lock in RUN: drop pll_lock -> ready/rst_out_n fall 3 edges later, pll_reset pulses for 4 cycles, retry_cnt=0, normal re-lock follows.
REQ-037 relock_req in RUN and in FAIL, including the same cycle as a WAIT timeout -> next state RST, retry_cnt=0, fail=0 on the next edge.
REQ-038 rst_n pulsed low mid-WAIT, asynchronous to clk -> all outputs take reset values within the same cycle, without waiting for a clk edge.
